// File: rtl/tick_ctrl.sv
// ============================================================================
//  Module      : tick_ctrl
//  Description : Rate-selectable tick controller. One prescale counter is
//                sequenced through idle, free-run and single-step modes and
//                produces a one-cycle tick enable plus a 50 % square wave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_ctrl #(
    parameter int N      = 26,
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic [1:0] rate_sel,
    output logic       tick,
    output logic       sq,
    output logic       running,
    output logic       busy,
    output logic [1:0] rate_cur
);

    // Terminal counts (D-1) and half points (D/2) for 1, 2, 4 and 10 Hz
    localparam logic [N-1:0] c_last_1hz  = N'(CLK_HZ - 1);
    localparam logic [N-1:0] c_last_2hz  = N'(CLK_HZ / 2 - 1);
    localparam logic [N-1:0] c_last_4hz  = N'(CLK_HZ / 4 - 1);
    localparam logic [N-1:0] c_last_10hz = N'(CLK_HZ / 10 - 1);
    localparam logic [N-1:0] c_half_1hz  = N'(CLK_HZ / 2);
    localparam logic [N-1:0] c_half_2hz  = N'((CLK_HZ / 2) / 2);
    localparam logic [N-1:0] c_half_4hz  = N'((CLK_HZ / 4) / 2);
    localparam logic [N-1:0] c_half_10hz = N'((CLK_HZ / 10) / 2);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_step = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [N-1:0] r_cnt;
    logic [1:0]   r_rate;
    logic [N-1:0] w_last;
    logic [N-1:0] w_half;
    logic         w_at_last;
    logic         w_active;

    // Divisor decode always follows the latched rate, never rate_sel
    always_comb begin
        w_last = c_last_1hz;
        w_half = c_half_1hz;
        case (r_rate)
            2'b00: begin w_last = c_last_1hz;  w_half = c_half_1hz;  end
            2'b01: begin w_last = c_last_2hz;  w_half = c_half_2hz;  end
            2'b10: begin w_last = c_last_4hz;  w_half = c_half_4hz;  end
            default: begin w_last = c_last_10hz; w_half = c_half_10hz; end
        endcase
    end

    assign w_at_last = (r_cnt == w_last);
    assign w_active  = (r_state == c_st_run) || (r_state == c_st_step);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; stop dominates, start beats step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (stop)       w_state_nxt = c_st_idle;
                else if (start) w_state_nxt = c_st_run;
                else if (step)  w_state_nxt = c_st_step;
            end
            c_st_run: begin
                if (stop) w_state_nxt = c_st_idle;
            end
            c_st_step: begin
                if (stop)           w_state_nxt = c_st_idle;
                else if (start)     w_state_nxt = c_st_run;
                else if (w_at_last) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Prescale counter: zero whenever idle or leaving idle, else count and wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_nxt == c_st_idle || !w_active) begin
            r_cnt <= '0;
        end else if (w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Rate latch: tracks rate_sel while idle, otherwise only at a period boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rate <= 2'b00;
        end else if (!w_active || w_at_last) begin
            r_rate <= rate_sel;
        end
    end

    // Moore outputs decoded from registered state and count
    always_comb begin
        busy     = w_active;
        running  = (r_state == c_st_run);
        tick     = w_active && w_at_last;
        sq       = w_active && (r_cnt >= w_half);
        rate_cur = r_rate;
    end

endmodule

`default_nettype wire

// File: tb/tb_tick_ctrl.sv
// ============================================================================
//  Module      : tb_tick_ctrl
//  Description : Self-checking bench for tick_ctrl (CLK_HZ=40, N=6) with a
//                period-level reference model, directed scenarios and
//                randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_ctrl;

    localparam int c_clk_hz = 40;
    localparam int c_n      = 6;

    logic       clk = 1'b0;
    logic       r_reset, r_start, r_stop, r_step;
    logic [1:0] r_rate_sel;
    logic       w_tick, w_sq, w_running, w_busy;
    logic [1:0] w_rate_cur;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = idle, 1 = free-run, 2 = single step
    int         m_mode = 0;
    int         m_pos  = 0;
    logic [1:0] m_rate = 2'b00;

    tick_ctrl #(.N(c_n), .CLK_HZ(c_clk_hz)) dut (
        .clk      (clk),
        .reset    (r_reset),
        .start    (r_start),
        .stop     (r_stop),
        .step     (r_step),
        .rate_sel (r_rate_sel),
        .tick     (w_tick),
        .sq       (w_sq),
        .running  (w_running),
        .busy     (w_busy),
        .rate_cur (w_rate_cur)
    );

    always #5 clk = ~clk;

    function automatic int period_of(input logic [1:0] r);
        int hz;
        case (r)
            2'b00:   hz = 1;
            2'b01:   hz = 2;
            2'b10:   hz = 4;
            default: hz = 10;
        endcase
        return c_clk_hz / hz;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at the edge
    task automatic model_edge();
        int  d;
        bit  end_of_period;
        d = period_of(m_rate);
        end_of_period = (m_mode != 0) && (m_pos == d - 1);
        if (r_reset) begin
            m_mode = 0; m_pos = 0; m_rate = 2'b00;
        end else begin
            if (m_mode == 0 || end_of_period) m_rate = r_rate_sel;
            if (m_mode == 0) begin
                m_pos = 0;
                if (!r_stop && r_start)     m_mode = 1;
                else if (!r_stop && r_step) m_mode = 2;
            end else if (r_stop) begin
                m_mode = 0; m_pos = 0;
            end else if (m_mode == 2 && !r_start && end_of_period) begin
                m_mode = 0; m_pos = 0;
            end else begin
                m_mode = 1 + ((m_mode == 2 && !r_start) ? 1 : 0);
                m_pos  = (m_pos + 1) % d;
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare every output
    task automatic cyc(input logic rs, st, sp, stp, input logic [1:0] sel);
        int d;
        r_reset = rs; r_start = st; r_stop = sp; r_step = stp; r_rate_sel = sel;
        @(posedge clk);
        model_edge();
        #1;
        d = period_of(m_rate);
        check("tick",     int'(w_tick),     int'(m_mode != 0 && m_pos == d - 1));
        check("sq",       int'(w_sq),       int'(m_mode != 0 && m_pos >= d / 2));
        check("running",  int'(w_running),  int'(m_mode == 1));
        check("busy",     int'(w_busy),     int'(m_mode != 0));
        check("rate_cur", int'(w_rate_cur), int'(m_rate));
    endtask

    initial begin
        int n_tick, n_busy, guard;
        r_reset = 1'b1; r_start = 1'b0; r_stop = 1'b0; r_step = 1'b0; r_rate_sel = 2'b00;

        // Reset state
        cyc(1, 0, 0, 0, 2'b11);
        cyc(1, 0, 0, 0, 2'b11);
        check("reset_busy", int'(w_busy), 0);

        // 10 Hz free run: tick every 4 cycles
        cyc(0, 1, 0, 0, 2'b11);
        n_tick = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 2'b11);
            n_tick += int'(w_tick);
        end
        check("run10_ticks", n_tick, 3);
        check("run10_rate", int'(w_rate_cur), 3);

        // Rate change mid-period does not disturb the current period
        cyc(0, 0, 1, 0, 2'b00);
        cyc(0, 1, 0, 0, 2'b00);
        guard = 0;
        while (m_pos != 15 && guard < 100) begin cyc(0, 0, 0, 0, 2'b00); guard++; end
        n_tick = 0;
        guard  = 0;
        do begin cyc(0, 0, 0, 0, 2'b10); n_tick++; guard++; end
        while (!w_tick && guard < 60);
        check("ratechg_first_tick_delay", n_tick, 24);
        check("ratechg_rate_before_wrap", int'(w_rate_cur), 0);
        n_tick = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0, 0, 2'b10);
            n_tick += int'(w_tick);
        end
        check("ratechg_ticks_after", n_tick, 3);
        check("ratechg_rate_after", int'(w_rate_cur), 2);

        // Single step at 2 Hz: 20 busy cycles, one tick, then quiet
        cyc(0, 0, 1, 0, 2'b01);
        cyc(0, 0, 0, 0, 2'b01);
        cyc(0, 0, 0, 1, 2'b01);
        n_busy = int'(w_busy);
        n_tick = int'(w_tick);
        for (int i = 0; i < 119; i++) begin
            cyc(0, 0, 0, 0, 2'b01);
            n_busy += int'(w_busy);
            n_tick += int'(w_tick);
        end
        check("step_busy_cycles", n_busy, 20);
        check("step_tick_count", n_tick, 1);

        // start+stop together in idle, then stop mid-run
        cyc(0, 1, 1, 0, 2'b00);
        check("startstop_busy", int'(w_busy), 0);
        cyc(0, 1, 0, 0, 2'b00);
        guard = 0;
        while (m_pos != 7 && guard < 100) begin cyc(0, 0, 0, 0, 2'b00); guard++; end
        cyc(0, 0, 1, 0, 2'b00);
        check("stop_busy", int'(w_busy), 0);

        // Reset mid-run with start held high
        cyc(0, 1, 0, 0, 2'b00);
        guard = 0;
        while (m_pos != 30 && guard < 100) begin cyc(0, 0, 0, 0, 2'b00); guard++; end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 2'b00);
            check("reset_run_busy", int'(w_busy), 0);
        end
        cyc(0, 1, 0, 0, 2'b00);
        check("post_reset_running", int'(w_running), 1);

        // Step promoted to run mid-period keeps counting
        cyc(0, 0, 1, 0, 2'b01);
        cyc(0, 0, 0, 1, 2'b01);
        guard = 0;
        while (m_pos != 12 && guard < 100) begin cyc(0, 0, 0, 0, 2'b01); guard++; end
        cyc(0, 1, 0, 0, 2'b01);
        n_tick = 0;
        for (int i = 0; i < 45; i++) begin
            cyc(0, 0, 0, 0, 2'b01);
            n_tick += int'(w_tick);
        end
        check("step2run_ticks", n_tick, 2);
        check("step2run_running", int'(w_running), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 19) == 0),
                2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tick_ctrl.md
# tick_ctrl

Rate-selectable tick controller for the board's timing chain. It owns a single prescale counter and sequences it through idle, free-run and single-step modes, producing a one-cycle `tick` enable and a 50 %-duty square wave `sq`. Downstream BCD/display counters consume `tick` as a clock enable. The block replaces fixed-rate dividers wherever the count rate must be chosen or paused at run time.

## Interface
- `N`, 26: width of the prescale counter; must hold `CLK_HZ-1`.
- `CLK_HZ`, 50000000: input clock frequency in Hz; must be ≥ 20.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset; dominates every other input.
- `start`  in  1  level; enter or stay in free-run.
- `stop`  in  1  level; return to idle. Wins over `start` and `step`.
- `step`  in  1  level; request exactly one period from idle.
- `rate_sel`  in  2  requested rate: 00 = 1 Hz, 01 = 2 Hz, 10 = 4 Hz, 11 = 10 Hz.
- `tick`  out  1  one-cycle pulse at the end of each period.
- `sq`  out  1  square wave, low in the first half of the period and high in the second.
- `running`  out  1  high in RUN.
- `busy`  out  1  high in RUN or STEP.
- `rate_cur`  out  2  rate currently in effect.

## Operation
- The divisor is `D = CLK_HZ / rate`, using integer division: `CLK_HZ`, `CLK_HZ/2`, `CLK_HZ/4`, `CLK_HZ/10`. It is computed from the latched `rate_cur`, never from `rate_sel` directly.
- The counter `cnt` counts 0 … D-1, then wraps to 0.
- FSM states: IDLE, RUN, STEP.
  - IDLE:
    - `stop`: stay in IDLE.
    - `start`: go to RUN.
    - `step` (without `start`): go to STEP.
    - `cnt` is held at 0.
  - RUN:
    - `stop`: go to IDLE and clear `cnt` to 0.
    - Otherwise `cnt` increments and wraps.
    - `step` is ignored.
  - STEP:
    - `stop`: go to IDLE with `cnt` = 0 and no tick.
    - `start`: go to RUN with `cnt` continuing uninterrupted.
    - Otherwise `cnt` increments. At `cnt == D-1` the block goes to IDLE and `cnt` becomes 0.
- `rate_cur` latching:
  - Loaded from `rate_sel` on every cycle spent in IDLE.
  - In RUN or STEP it is loaded only on the wrap edge (`cnt == D-1`).
  - A change of `rate_sel` mid-period therefore never truncates or stretches the current period.
- Outputs are Moore, decoded from registered state only:
  - `tick = busy && cnt == D-1`
  - `sq = busy && cnt >= D/2`
  - `running = (state == RUN)`
  - `busy = (state != IDLE)`
- Reset values: state IDLE, `cnt` 0, `rate_cur` 00. Hence `tick`, `sq`, `running` and `busy` are all 0 after reset.

## Timing
- `start` sampled at edge k in IDLE:
  - `cnt` = 0 and `running` = 1 after edge k.
  - The first `tick` is high in the cycle after edge k+D-1.
  - Ticks then repeat every D cycles.
- `tick` is exactly one cycle wide at every rate. The minimum D is `CLK_HZ/10` ≥ 2.
- `stop` sampled at edge k: after edge k, `busy`, `tick` and `sq` are all 0.
- `step`: `busy` is high for exactly D cycles, with a single tick in the last of them.
- Reset mid-operation: all outputs are 0 after the reset edge. `start`, `stop` and `step` are ignored while `reset` is high.
- Simultaneous inputs:
  - `start` + `stop` together: IDLE.
  - `start` + `step` in IDLE: RUN.

## Test plan
All scenarios use `CLK_HZ=40`, `N=6`, giving D = 40 / 20 / 10 / 4.
- Reset, `rate_sel`=11, pulse `start` → `tick` is high on `cnt`=3, every 4 cycles. `sq` is high on `cnt` 2–3. `running`=1 and `rate_cur`=11.
- RUN at `rate_sel`=00; switch to 10 at `cnt`=15 → the next tick still arrives at `cnt`=39. `rate_cur` becomes 10 after that wrap, and the following ticks are 10 cycles apart.
- IDLE, `rate_sel`=01, one-cycle `step` → `busy` is high for 20 cycles with one tick in the 20th, then IDLE with no further ticks over the next 100 cycles.
- `start` and `stop` together in IDLE → stays IDLE, all outputs 0. Then in RUN at D=40, `stop` at `cnt`=7 → next cycle `cnt`=0, `tick`=0, `sq`=0, `busy`=0.
- RUN at D=40; assert `reset` at `cnt`=30 for 3 cycles with `start` held high → all outputs 0 during reset. IDLE→RUN occurs on the first edge after `reset` falls.
- STEP at D=20; assert `start` at `cnt`=12 → RUN, ticks at `cnt`=19 and every 20 cycles thereafter, with no counter restart.
